// File: rtl/ex_div_if.sv
// Divider request/response bundle between the EX stage (master) and the divider (slave).
interface ex_div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/ex_div.sv
// 32-cycle restoring divider for DIV/DIVU; result is {remainder, quotient}.
module ex_div (
    input logic     clk,
    input logic     rst,
    ex_div_if.slave bus
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic        accept;
    logic [31:0] mag1, mag2;
    logic        trial_ge;
    logic [31:0] trial;
    logic [31:0] quo_fix, rem_fix;

    assign accept = bus.start_i && !bus.annul_i;
    assign mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
    assign mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;

    // Partial remainder is 33 bits wide; bit 64 set means it already exceeds any divisor.
    assign trial_ge = work_q[64] || (work_q[63:32] >= divisor_q);
    assign trial    = work_q[63:32] - divisor_q;
    assign quo_fix  = neg_quo_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
    assign rem_fix  = neg_rem_q ? (32'd0 - work_q[64:33]) : work_q[64:33];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FREE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE:    if (accept) state_d = (bus.opdata2_i == 32'd0) ? BYZERO : ON;
            BYZERO:  state_d = END;
            ON:      if (bus.annul_i) state_d = FREE;
                     else if (cnt_q == 6'd32) state_d = END;
            END:     if (!bus.start_i) state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    always_comb begin
        bus.ready_o  = (state_q == END);
        bus.result_o = (state_q == END) ? {work_q[64:33], work_q[31:0]} : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Layout of work: [64:33] remainder, [32:1] shifted dividend/quotient, [0] new quotient bit.
    always_comb begin
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            FREE: begin
                if (accept && bus.opdata2_i != 32'd0) begin
                    cnt_d     = '0;
                    work_d    = {32'd0, mag1, 1'b0};
                    divisor_d = mag2;
                    neg_quo_d = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                    neg_rem_d = bus.signed_div_i && bus.opdata1_i[31];
                end
            end
            BYZERO: work_d = '0;
            ON: begin
                if (bus.annul_i) begin
                    cnt_d  = '0;
                    work_d = '0;
                end else if (cnt_q < 6'd32) begin
                    cnt_d = cnt_q + 6'd1;
                    if (trial_ge) work_d = {trial, work_q[31:0], 1'b1};
                    else          work_d = {work_q[63:0], 1'b0};
                end else begin
                    work_d = {rem_fix, 1'b0, quo_fix};
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have the port signed_div_i, input, 1 bit: 1 means signed (DIV), 0 means unsigned (DIVU).
REQ-004 The block SHALL have the port opdata1_i, input, 32 bits: the dividend.
REQ-005 The block SHALL have the port opdata2_i, input, 32 bits: the divisor.
REQ-006 The block SHALL have the port start_i, input, 1 bit: the EX stage requests a divide and holds it until ready_o is seen.
REQ-007 The block SHALL have the port annul_i, input, 1 bit: abort the operation in flight (flush or exception).
REQ-008 The block SHALL have the port result_o, output, 64 bits: {remainder[63:32], quotient[31:0]}, bound for the hi/lo write path.
REQ-009 The block SHALL have the port ready_o, output, 1 bit: result_o is valid this cycle.

Function
REQ-010 The block SHALL be a four-state FSM: FREE, BYZERO, ON, END.
REQ-011 FREE, start_i=1, annul_i=0, opdata2_i=0: the block SHALL go to BYZERO.
REQ-012 FREE, start_i=1, annul_i=0, opdata2_i!=0: the block SHALL go to ON, clear the 6-bit iteration counter, and latch the operand magnitudes.
REQ-013 Magnitudes SHALL be two's-complement absolute values when signed_div_i=1 and the operand MSB=1; otherwise the raw operands.
REQ-014 FREE with start_i=0 or annul_i=1: the block SHALL stay in FREE, with ready_o=0 and result_o=0.
REQ-015 BYZERO: the block SHALL load quotient=0 and remainder=0 and go to END on the next edge.
REQ-016 ON, annul_i=0, counter<32: each edge SHALL perform one restoring step on the 65-bit working register {rem,quo} and increment the counter.
REQ-017 Restoring step: shift left 1, trial = rem[63:32] - divisor (33-bit); if trial is non-negative, rem[63:32] = trial and LSB = 1, else LSB = 0.
REQ-018 ON, counter=32: the block SHALL apply sign correction and go to END.
REQ-019 Sign correction (signed only): negate the quotient when the operand signs differ; negate the remainder when the dividend is negative.
REQ-020 ON, annul_i=1: the block SHALL go to FREE on that edge, discard partial results, and not assert ready_o.
REQ-021 END: ready_o SHALL be 1 and result_o SHALL hold the final value.
REQ-022 The block SHALL remain in END while start_i=1.
REQ-023 END, start_i=0: the block SHALL go to FREE, with ready_o and result_o returning to 0.
REQ-024 annul_i in END SHALL have no effect; start_i governs the exit.
REQ-025 Latency, nonzero divisor: start sampled at edge E0 gives ready_o=1 after E33 (34 edges).
REQ-026 Latency, zero divisor: ready_o=1 after E1.
REQ-027 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-028 Operand inputs SHALL be sampled only at the FREE->ON edge; later changes SHALL not affect the result.
REQ-029 The EX stage SHALL stall the pipeline while start_i=1 and ready_o=0; this block SHALL not generate stall itself.

Reset
REQ-030 rst=1 SHALL immediately, with no clock edge needed, force state FREE, counter 0, working register 0, ready_o=0 and result_o=0.
REQ-031 Reset asserted in any state, including mid-ON, SHALL abandon the operation.
REQ-032 After rst deasserts, the first start_i=1 SHALL begin a fresh divide.

Verification
REQ-033 Unsigned 100/7 held with start_i until ready -> after 34 edges ready_o=1, result_o={0x00000002,0x0000000E}; start_i=0 -> ready_o=0 on the next edge.
REQ-034 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-035 Divide by zero, 5/0 -> ready_o=1 two edges after start, result_o=0.
REQ-036 Signed 0x80000000/0xFFFFFFFF -> {0x00000000,0x80000000}, no hang.
REQ-037 annul_i=1 at iteration 10 -> FREE next edge, ready_o never asserts; an immediate new 9/3 start gives quotient 3, remainder 0.
REQ-038 rst pulsed mid-ON, between clock edges -> outputs 0 at once; the block accepts a new start after release.
